breakout_game_ctrl: RTL and testbench

Top-level game sequencer for Breakout. Runs the game-state machine (idle, serve, play, miss, over, win) and gates the ball datapath with `ball_step` enable strobes paced by the frame tick. Drives the ball and brick-field resets, counts lives and score from brick-erase events, and raises ball speed as score grows. Sits between the VGA frame timing, the start button and the ball/brick datapath.

---
 rtl/breakout_game_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_breakout_game_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: game-state FSM, lives/score/level bookkeeping and
// frame-paced ball_step scheduling for the ball/brick datapath.
module breakout_game_ctrl #(
    parameter int         LIVES        = 3,
    parameter int         BLOCKS       = 10,
    parameter int         SERVE_FRAMES = 60,
    parameter logic [9:0] MISS_Y       = 10'd473,
    parameter int         STEP_GAP     = 16,
    parameter int         MAX_LEVEL    = 3,
    parameter int         LEVEL_BLOCKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_tick,
    input  logic       i_start_btn,
    input  logic       i_erase_enable,
    input  logic [9:0] i_ball_y,
    output logic       o_ball_step,
    output logic       o_ball_rst,
    output logic       o_field_rst,
    output logic [1:0] o_lives,
    output logic [7:0] o_score,
    output logic [1:0] o_level,
    output logic [2:0] o_state,
    output logic       o_game_over,
    output logic       o_game_won
);

    // state | meaning
    // IDLE  | power-up, waiting for first start edge
    // SERVE | ball held at serve position for SERVE_FRAMES ticks
    // PLAY  | ball moving, bricks being erased
    // MISS  | single cycle, lose a life
    // OVER  | no lives left, waiting for start edge
    // WIN   | field cleared, waiting for start edge
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_MISS  = 3'd3,
        ST_OVER  = 3'd4,
        ST_WIN   = 3'd5
    } state_t;

    localparam int SERVE_W = $clog2(SERVE_FRAMES + 1);
    localparam int BLK_W   = $clog2(BLOCKS + 1);
    localparam int GAP_W   = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_start_prev;
    logic [SERVE_W-1:0] r_serve_cnt;
    logic [BLK_W-1:0]   r_blocks_left;
    logic [1:0]         r_lives;
    logic [7:0]         r_score;
    logic [1:0]         r_level;
    logic [1:0]         r_pending;
    logic [GAP_W-1:0]   r_gap;
    logic               r_ball_step;
    logic               r_ball_rst;
    logic               r_field_rst;
    logic               r_game_over;
    logic               r_game_won;

    logic               w_start_edge;
    logic               w_erase;
    logic               w_last_brick;
    logic               w_miss;
    logic               w_serve_done;
    logic               w_restart;
    logic               w_sched_on;
    logic               w_ball_rst_next;
    logic               w_field_rst_next;
    logic [7:0]         w_level_calc;

    assign w_start_edge = i_start_btn & ~r_start_prev;
    assign w_erase      = i_erase_enable && (r_state == ST_PLAY);
    assign w_last_brick = (r_state == ST_PLAY) &&
                          ((w_erase && r_blocks_left == BLK_W'(1)) || r_blocks_left == '0);
    assign w_miss       = i_tick && (i_ball_y >= MISS_Y);
    assign w_serve_done = i_tick && (r_serve_cnt <= SERVE_W'(1));
    assign w_restart    = ((r_state == ST_OVER) || (r_state == ST_WIN)) && w_start_edge;
    // Scheduler runs only while PLAY persists, so no step leaks into MISS/WIN.
    assign w_sched_on   = (r_state == ST_PLAY) && (w_state_next == ST_PLAY);
    assign w_level_calc = 8'd1 + (r_score / 8'(LEVEL_BLOCKS));

    always_comb begin
        w_state_next     = r_state;
        w_ball_rst_next  = 1'b1;
        w_field_rst_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) w_state_next = ST_SERVE;
            end
            ST_SERVE: begin
                if (w_serve_done) w_state_next = ST_PLAY;
            end
            ST_PLAY: begin
                if (w_last_brick)  w_state_next = ST_WIN;
                else if (w_miss)   w_state_next = ST_MISS;
            end
            ST_MISS: begin
                if (r_lives <= 2'd1) w_state_next = ST_OVER;
                else                 w_state_next = ST_SERVE;
            end
            ST_OVER, ST_WIN: begin
                if (w_start_edge) w_state_next = ST_SERVE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        w_ball_rst_next  = (w_state_next != ST_PLAY);
        w_field_rst_next = (w_state_next == ST_IDLE) || w_restart;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_start_prev <= 1'b0;
            r_ball_rst   <= 1'b1;
            r_field_rst  <= 1'b1;
            r_game_over  <= 1'b0;
            r_game_won   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_start_prev <= i_start_btn;
            r_ball_rst   <= w_ball_rst_next;
            r_field_rst  <= w_field_rst_next;
            r_game_over  <= (w_state_next == ST_OVER);
            r_game_won   <= (w_state_next == ST_WIN);
        end
    end

    // Serve hold: reloaded on every entry into SERVE, counts ticks down to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_serve_cnt <= SERVE_W'(SERVE_FRAMES);
        end else if ((w_state_next == ST_SERVE) && (r_state != ST_SERVE)) begin
            r_serve_cnt <= SERVE_W'(SERVE_FRAMES);
        end else if ((r_state == ST_SERVE) && i_tick && (r_serve_cnt != '0)) begin
            r_serve_cnt <= r_serve_cnt - SERVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lives       <= 2'(LIVES);
            r_score       <= 8'd0;
            r_blocks_left <= BLK_W'(BLOCKS);
            r_level       <= 2'd1;
        end else begin
            if (w_restart) begin
                r_lives       <= 2'(LIVES);
                r_score       <= 8'd0;
                r_blocks_left <= BLK_W'(BLOCKS);
            end else begin
                if ((r_state == ST_MISS) && (r_lives != 2'd0)) r_lives <= r_lives - 2'd1;
                if (w_erase) begin
                    if (r_score != 8'hFF)        r_score       <= r_score + 8'd1;
                    if (r_blocks_left != '0)     r_blocks_left <= r_blocks_left - BLK_W'(1);
                end
            end
            // Level trails score by one cycle.
            if (w_level_calc >= 8'(MAX_LEVEL)) r_level <= 2'(MAX_LEVEL);
            else                               r_level <= w_level_calc[1:0];
        end
    end

    // A tick fires the first step at once; remaining steps wait out the gap.
    always_ff @(posedge clk) begin
        if (reset || !w_sched_on) begin
            r_pending   <= 2'd0;
            r_gap       <= '0;
            r_ball_step <= 1'b0;
        end else if (i_tick) begin
            r_ball_step <= (r_level != 2'd0);
            r_pending   <= (r_level != 2'd0) ? (r_level - 2'd1) : 2'd0;
            r_gap       <= GAP_W'(STEP_GAP - 1);
        end else if ((r_pending != 2'd0) && (r_gap == '0)) begin
            r_ball_step <= 1'b1;
            r_pending   <= r_pending - 2'd1;
            r_gap       <= GAP_W'(STEP_GAP - 1);
        end else begin
            r_ball_step <= 1'b0;
            if (r_gap != '0) r_gap <= r_gap - GAP_W'(1);
        end
    end

    assign o_ball_step = r_ball_step;
    assign o_ball_rst  = r_ball_rst;
    assign o_field_rst = r_field_rst;
    assign o_lives     = r_lives;
    assign o_score     = r_score;
    assign o_level     = r_level;
    assign o_state     = r_state;
    assign o_game_over = r_game_over;
    assign o_game_won  = r_game_won;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Directed bench for breakout_game_ctrl: serve timing, step pacing, misses,
// win priority, restart edge detection and mid-game reset.
module tb_breakout_game_ctrl;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       start_btn;
    logic       erase_enable;
    logic [9:0] ball_y;
    logic       ball_step;
    logic       ball_rst;
    logic       field_rst;
    logic [1:0] lives;
    logic [7:0] score;
    logic [1:0] level;
    logic [2:0] state;
    logic       game_over;
    logic       game_won;

    int checks   = 0;
    int failures = 0;

    breakout_game_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .i_tick         (tick),
        .i_start_btn    (start_btn),
        .i_erase_enable (erase_enable),
        .i_ball_y       (ball_y),
        .o_ball_step    (ball_step),
        .o_ball_rst     (ball_rst),
        .o_field_rst    (field_rst),
        .o_lives        (lives),
        .o_score        (score),
        .o_level        (level),
        .o_state        (state),
        .o_game_over    (game_over),
        .o_game_won     (game_won)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, required finish before 1ms");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic do_erase();
        erase_enable = 1'b1;
        cyc();
        erase_enable = 1'b0;
    endtask

    task automatic do_miss(input logic [9:0] y);
        ball_y = y;
        do_tick();
        ball_y = 10'd100;
    endtask

    // Tick once, then record which of the following cycles carry a ball_step.
    task automatic run_window(input int n, input int retick_at, output logic [63:0] mask);
        mask = '0;
        do_tick();
        for (int k = 1; k <= n; k++) begin
            if (ball_step === 1'b1) mask[k] = 1'b1;
            tick = (k == retick_at);
            cyc();
        end
        tick = 1'b0;
    endtask

    task automatic count_steps(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            tick = (k % 8 == 0);
            cyc();
            if (ball_step === 1'b1) cnt++;
        end
        tick = 1'b0;
    endtask

    task automatic serve_to_play();
        int n;
        int bad;
        n = 0;
        bad = 0;
        for (int i = 0; i < 70 && state === 3'd1; i++) begin
            do_tick();
            n++;
            if (state === 3'd1) begin
                if (ball_rst !== 1'b1 || field_rst !== 1'b0 || ball_step !== 1'b0) bad++;
                cyc();
            end
        end
        checks++;
        if (n != 60) begin
            failures++;
            $display("FAIL serve_ticks: got %0d ticks in SERVE, required 60", n);
        end
        checks++;
        if (state !== 3'd2 || ball_rst !== 1'b0) begin
            failures++;
            $display("FAIL serve_to_play: state=%0d ball_rst=%b, required state=2 ball_rst=0", state, ball_rst);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL serve_outputs: %0d serve cycles with wrong ball_rst/field_rst/ball_step, required 0", bad);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; tick = 1'b0; start_btn = 1'b0; erase_enable = 1'b0; ball_y = 10'd100;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        checks++;
        if (state !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d required 0", state); end
        checks++;
        if (lives !== 2'd3 || score !== 8'd0 || level !== 2'd1) begin
            failures++;
            $display("FAIL reset_counts: lives=%0d score=%0d level=%0d, required 3 0 1", lives, score, level);
        end
        checks++;
        if (ball_step !== 1'b0 || ball_rst !== 1'b1 || field_rst !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctrl: step=%b ball_rst=%b field_rst=%b, required 0 1 1", ball_step, ball_rst, field_rst);
        end
        checks++;
        if (game_over !== 1'b0 || game_won !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: over=%b won=%b, required 0 0", game_over, game_won);
        end
    endtask

    task automatic test_start();
        do_tick();
        checks++;
        if (state !== 3'd0) begin failures++; $display("FAIL idle_tick: state=%0d required 0", state); end
        start_btn = 1'b1;
        cyc();
        start_btn = 1'b0;
        checks++;
        if (state !== 3'd1 || field_rst !== 1'b0 || ball_rst !== 1'b1) begin
            failures++;
            $display("FAIL start_edge: state=%0d field_rst=%b ball_rst=%b, required 1 0 1", state, field_rst, ball_rst);
        end
        serve_to_play();
    endtask

    task automatic test_step_pacing();
        logic [63:0] mask;
        ball_y = 10'd472;
        run_window(50, -1, mask);
        ball_y = 10'd100;
        checks++;
        if (mask !== 64'h2 || state !== 3'd2) begin
            failures++;
            $display("FAIL pace_level1: step mask=%h state=%0d, required mask=2 state=2", mask, state);
        end
        for (int i = 0; i < 4; i++) do_erase();
        checks++;
        if (score !== 8'd4 || level !== 2'd1) begin
            failures++;
            $display("FAIL score4_latency: score=%0d level=%0d, required 4 1", score, level);
        end
        cyc();
        checks++;
        if (level !== 2'd2) begin failures++; $display("FAIL level2: level=%0d required 2", level); end
        for (int i = 0; i < 4; i++) do_erase();
        cyc();
        checks++;
        if (score !== 8'd8 || level !== 2'd3) begin
            failures++;
            $display("FAIL level3: score=%0d level=%0d, required 8 3", score, level);
        end
        run_window(50, -1, mask);
        checks++;
        if (mask !== ((64'd1 << 1) | (64'd1 << 17) | (64'd1 << 33))) begin
            failures++;
            $display("FAIL pace_level3: step mask=%h required %h", mask, (64'd1 << 1) | (64'd1 << 17) | (64'd1 << 33));
        end
    endtask

    task automatic test_tick_reload();
        logic [63:0] mask;
        run_window(50, 5, mask);
        checks++;
        if (mask !== ((64'd1 << 1) | (64'd1 << 6) | (64'd1 << 22) | (64'd1 << 38))) begin
            failures++;
            $display("FAIL tick_reload: step mask=%h required %h", mask,
                     (64'd1 << 1) | (64'd1 << 6) | (64'd1 << 22) | (64'd1 << 38));
        end
    endtask

    task automatic test_miss_and_win();
        int cnt;
        do_miss(10'd473);
        checks++;
        if (state !== 3'd3 || ball_step !== 1'b0 || lives !== 2'd3) begin
            failures++;
            $display("FAIL miss_enter: state=%0d step=%b lives=%0d, required 3 0 3", state, ball_step, lives);
        end
        cyc();
        checks++;
        if (state !== 3'd1 || lives !== 2'd2) begin
            failures++;
            $display("FAIL miss_to_serve: state=%0d lives=%0d, required 1 2", state, lives);
        end
        do_erase();
        cyc();
        checks++;
        if (score !== 8'd8) begin failures++; $display("FAIL erase_in_serve: score=%0d required 8", score); end
        serve_to_play();
        do_erase();
        checks++;
        if (score !== 8'd9 || state !== 3'd2) begin
            failures++;
            $display("FAIL erase9: score=%0d state=%0d, required 9 2", score, state);
        end
        erase_enable = 1'b1; tick = 1'b1; ball_y = 10'd475;
        cyc();
        erase_enable = 1'b0; tick = 1'b0; ball_y = 10'd100;
        checks++;
        if (state !== 3'd5 || lives !== 2'd2 || score !== 8'd10) begin
            failures++;
            $display("FAIL win_priority: state=%0d lives=%0d score=%0d, required 5 2 10", state, lives, score);
        end
        checks++;
        if (game_won !== 1'b1 || game_over !== 1'b0 || ball_rst !== 1'b1 || ball_step !== 1'b0) begin
            failures++;
            $display("FAIL win_flags: won=%b over=%b ball_rst=%b step=%b, required 1 0 1 0",
                     game_won, game_over, ball_rst, ball_step);
        end
        count_steps(30, cnt);
        checks++;
        if (cnt != 0 || state !== 3'd5) begin
            failures++;
            $display("FAIL win_idle: steps=%0d state=%0d, required 0 5", cnt, state);
        end
    endtask

    task automatic test_restart_from_win();
        start_btn = 1'b1;
        cyc();
        checks++;
        if (state !== 3'd1 || field_rst !== 1'b1 || lives !== 2'd3 || score !== 8'd0 || game_won !== 1'b0) begin
            failures++;
            $display("FAIL restart_win: state=%0d field_rst=%b lives=%0d score=%0d won=%b, required 1 1 3 0 0",
                     state, field_rst, lives, score, game_won);
        end
        cyc();
        checks++;
        if (field_rst !== 1'b0 || level !== 2'd1 || state !== 3'd1) begin
            failures++;
            $display("FAIL restart_pulse: field_rst=%b level=%0d state=%0d, required 0 1 1", field_rst, level, state);
        end
    endtask

    // start_btn stays high from the previous restart throughout this scenario.
    task automatic test_lose_all_lives();
        int cnt;
        for (int m = 0; m < 3; m++) begin
            serve_to_play();
            if (m == 0) begin
                do_erase();
                do_erase();
            end
            do_miss(10'd475);
            checks++;
            if (state !== 3'd3) begin failures++; $display("FAIL miss%0d_state: state=%0d required 3", m, state); end
            cyc();
            checks++;
            if (lives !== 2'(2 - m) || state !== ((m == 2) ? 3'd4 : 3'd1)) begin
                failures++;
                $display("FAIL miss%0d_after: lives=%0d state=%0d, required %0d %0d",
                         m, lives, state, 2 - m, (m == 2) ? 4 : 1);
            end
        end
        checks++;
        if (game_over !== 1'b1 || game_won !== 1'b0 || ball_rst !== 1'b1 || score !== 8'd2) begin
            failures++;
            $display("FAIL over_flags: over=%b won=%b ball_rst=%b score=%0d, required 1 0 1 2",
                     game_over, game_won, ball_rst, score);
        end
        count_steps(30, cnt);
        checks++;
        if (cnt != 0 || state !== 3'd4) begin
            failures++;
            $display("FAIL over_held_start: steps=%0d state=%0d, required 0 4", cnt, state);
        end
    endtask

    task automatic test_restart_from_over();
        start_btn = 1'b0;
        cyc();
        start_btn = 1'b1;
        cyc();
        checks++;
        if (state !== 3'd1 || field_rst !== 1'b1 || lives !== 2'd3 || score !== 8'd0 || game_over !== 1'b0) begin
            failures++;
            $display("FAIL restart_over: state=%0d field_rst=%b lives=%0d score=%0d over=%b, required 1 1 3 0 0",
                     state, field_rst, lives, score, game_over);
        end
        cyc();
        start_btn = 1'b0;
        checks++;
        if (field_rst !== 1'b0) begin failures++; $display("FAIL restart_over_pulse: field_rst=%b required 0", field_rst); end
    endtask

    task automatic test_mid_reset();
        int cnt;
        serve_to_play();
        for (int i = 0; i < 4; i++) do_erase();
        cyc();
        checks++;
        if (level !== 2'd2) begin failures++; $display("FAIL pre_reset_level: level=%0d required 2", level); end
        do_tick();
        checks++;
        if (ball_step !== 1'b1) begin failures++; $display("FAIL pre_reset_step: step=%b required 1", ball_step); end
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++;
        if ({state, lives, score, level, ball_step, ball_rst, field_rst, game_over, game_won} !==
            {3'd0, 2'd3, 8'd0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset: state=%0d lives=%0d score=%0d level=%0d step=%b ball_rst=%b field_rst=%b over=%b won=%b, required 0 3 0 1 0 1 1 0 0",
                     state, lives, score, level, ball_step, ball_rst, field_rst, game_over, game_won);
        end
        count_steps(24, cnt);
        checks++;
        if (cnt != 0 || state !== 3'd0) begin
            failures++;
            $display("FAIL post_reset_idle: steps=%0d state=%0d, required 0 0", cnt, state);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_step_pacing();
        test_tick_reload();
        test_miss_and_win();
        test_restart_from_win();
        test_lose_all_lives();
        test_restart_from_over();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
